// File: rtl/gl64_bfly_core_if.sv
// gl64_bfly_core_if
// Bundles the butterfly data path of gl64_bfly_core. The core has no
// handshake, so this carries only the enable, the bypass flag, the three
// operands and the two results.
//   master : drives ce_i, nop_i, x_i, y_i, w_i; receives x_o, y_o
//   slave  : the core side (receives operands, drives results)
interface gl64_bfly_core_if;
    logic        ce_i;
    logic        nop_i;
    logic [63:0] x_i;
    logic [63:0] y_i;
    logic [63:0] w_i;
    logic [63:0] x_o;
    logic [63:0] y_o;

    modport master (output ce_i, nop_i, x_i, y_i, w_i, input x_o, y_o);
    modport slave  (input ce_i, nop_i, x_i, y_i, w_i, output x_o, y_o);
endinterface

// File: rtl/gl64_bfly_core.sv
// gl64_bfly_core
// Pipelined radix-2 butterfly over the Goldilocks field p = 2^64 - 2^32 + 1:
//   x_o = x + y mod p,   y_o = (x - y) * w mod p
// Parameters:
//   MODE      0 = GENERIC (full multiply, latency 8)
//             1 = W0      (y_o = x - y, latency 2)
//             2 = W0_W2   (multiply by 1 or 2^48 via w_i[0], latency 5)
//   BFLYDSP   multiplier mapping hint: 24 = one wide product, otherwise the
//             product is built from four 32x32 partials; same result.
//   CANONICAL 1 = add/sub results fully reduced into [0, p)
// Ports:
//   clk_i  rising-edge clock
//   rst_ni asynchronous active-low reset, clears every data register
//   bus    gl64_bfly_core_if.slave: ce_i (enable for all registers),
//          nop_i (bypass, x_o = x_i, y_o = y_i), x_i, y_i, w_i in; x_o, y_o out
// Optional macro GL64_BFLY_SELFCHECK_EN adds a simulation-only shadow checker.
module gl64_bfly_core #(
    parameter int MODE      = 0,
    parameter int BFLYDSP   = 24,
    parameter int CANONICAL = 0
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    gl64_bfly_core_if.slave bus
);
    localparam logic [63:0] P_MOD = 64'hFFFF_FFFF_0000_0001;
    localparam logic [64:0] EPS   = 65'h0_FFFF_FFFF;
    localparam int          LAT   = (MODE == 1) ? 2 : ((MODE == 2) ? 5 : 8);

    logic [64:0] sRaw_q, dRaw_q, s1, d1;
    logic [63:0] s2, d2, sum_d, diff_d, sum_q, diff_q;
    logic        nop1_q;

    // Stage 1: raw 65-bit sum and difference; bit 64 is the carry or borrow.
    // A bypassed butterfly loads x and y untouched so no correction fires.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sRaw_q <= '0;
            dRaw_q <= '0;
            nop1_q <= 1'b0;
        end else if (bus.ce_i) begin
            sRaw_q <= bus.nop_i ? {1'b0, bus.x_i} : {1'b0, bus.x_i} + {1'b0, bus.y_i};
            dRaw_q <= bus.nop_i ? {1'b0, bus.y_i} : {1'b0, bus.x_i} - {1'b0, bus.y_i};
            nop1_q <= bus.nop_i;
        end
    end

    // Fold carries/borrows using 2^64 == 2^32 - 1 (mod p). Two folds always
    // suffice; after the second one the value fits in 64 bits exactly.
    always_comb begin
        s1     = sRaw_q[64] ? ({1'b0, sRaw_q[63:0]} + EPS) : sRaw_q;
        s2     = s1[64] ? (s1[63:0] + EPS[63:0]) : s1[63:0];
        d1     = dRaw_q[64] ? ({1'b0, dRaw_q[63:0]} - EPS) : dRaw_q;
        d2     = d1[64] ? (d1[63:0] - EPS[63:0]) : d1[63:0];
        sum_d  = s2;
        diff_d = d2;
        if (CANONICAL != 0 && !nop1_q) begin
            if (sum_d >= P_MOD)  sum_d  = sum_d - P_MOD;
            if (diff_d >= P_MOD) diff_d = diff_d - P_MOD;
        end
    end

    // Stage 2: corrected add/sub results.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q  <= '0;
            diff_q <= '0;
        end else if (bus.ce_i) begin
            sum_q  <= sum_d;
            diff_q <= diff_d;
        end
    end

    generate
        if (MODE == 1) begin : g_w0
            assign bus.x_o = sum_q;
            assign bus.y_o = diff_q;
        end else begin : g_mul
            // W0_W2 only needs the select bit, so its twiddle pipe is 1 bit wide.
            localparam int WW = (MODE == 2) ? 1 : 64;
            localparam int XD = LAT - 2;
            logic [WW-1:0] w1_q, w2_q;
            logic [127:0]  prod;
            logic [65:0]   lo_q, r_q;
            logic [63:0]   mid_q, y_q;
            logic [63:0]   xDly_q [XD];

            // The effective twiddle (1 when bypassed) rides alongside the add/sub stages.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    w1_q <= '0;
                    w2_q <= '0;
                end else if (bus.ce_i) begin
                    w1_q <= bus.nop_i ? WW'(1) : bus.w_i[WW-1:0];
                    w2_q <= w1_q;
                end
            end

            if (MODE == 2) begin : g_w2
                // Multiplying by 2^48 is just a shift into the 128-bit product.
                assign prod = w2_q[0] ? {64'd0, diff_q} : {16'd0, diff_q, 48'd0};
            end else begin : g_gen
                logic [127:0] prod_d, m0_q, m1_q, m2_q;
                if (BFLYDSP == 24) begin : g_wide
                    assign prod_d = {64'd0, diff_q} * {64'd0, w2_q};
                end else begin : g_split
                    logic [63:0] ll, lh, hl, hh;
                    assign ll = {32'd0, diff_q[31:0]}  * {32'd0, w2_q[31:0]};
                    assign lh = {32'd0, diff_q[31:0]}  * {32'd0, w2_q[63:32]};
                    assign hl = {32'd0, diff_q[63:32]} * {32'd0, w2_q[31:0]};
                    assign hh = {32'd0, diff_q[63:32]} * {32'd0, w2_q[63:32]};
                    assign prod_d = {64'd0, ll} + ({64'd0, lh} << 32)
                                  + ({64'd0, hl} << 32) + {hh, 64'd0};
                end

                // Three product registers leave room to retime the multiplier across DSP stages.
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) begin
                        m0_q <= '0;
                        m1_q <= '0;
                        m2_q <= '0;
                    end else if (bus.ce_i) begin
                        m0_q <= prod_d;
                        m1_q <= m0_q;
                        m2_q <= m1_q;
                    end
                end
                assign prod = m2_q;
            end

            // 128->64 reduction using 2^96 == -1 and 2^64 == 2^32 - 1 (mod p):
            // a 66-bit signed sum, then one add or subtract of p lands it in [0, 2^64).
            // The sum is delayed in step so it leaves with its matching product.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    lo_q  <= '0;
                    mid_q <= '0;
                    r_q   <= '0;
                    y_q   <= '0;
                    for (int i = 0; i < XD; i++) xDly_q[i] <= '0;
                end else if (bus.ce_i) begin
                    lo_q  <= {2'b00, prod[63:0]} - {34'd0, prod[127:96]};
                    mid_q <= {prod[95:64], 32'd0} - {32'd0, prod[95:64]};
                    r_q   <= lo_q + {2'b00, mid_q};
                    if (r_q[65])      y_q <= r_q[63:0] + P_MOD;
                    else if (r_q[64]) y_q <= r_q[63:0] - P_MOD;
                    else              y_q <= r_q[63:0];
                    xDly_q[0] <= sum_q;
                    for (int i = 1; i < XD; i++) xDly_q[i] <= xDly_q[i-1];
                end
            end
            assign bus.x_o = xDly_q[XD-1];
            assign bus.y_o = y_q;
        end
    endgenerate

`ifdef GL64_BFLY_SELFCHECK_EN
    // Shadow pipeline: carries raw inputs to the output stage and recomputes
    // the butterfly straight from the field arithmetic.
    logic [63:0] shX [LAT], shY [LAT], shW [LAT];
    logic        shN [LAT], shV [LAT];

    function automatic logic [127:0] refBfly(input logic [63:0] x, y, w, input logic nop);
        logic [64:0]  s, d;
        logic [127:0] pr;
        logic [65:0]  r;
        s = nop ? {1'b0, x} : {1'b0, x} + {1'b0, y};
        d = nop ? {1'b0, y} : {1'b0, x} - {1'b0, y};
        for (int k = 0; k < 2; k++) begin
            if (s[64]) s = {1'b0, s[63:0]} + EPS;
            if (d[64]) d = {1'b0, d[63:0]} - EPS;
        end
        if (CANONICAL != 0 && !nop) begin
            if (s[63:0] >= P_MOD) s = s - {1'b0, P_MOD};
            if (d[63:0] >= P_MOD) d = d - {1'b0, P_MOD};
        end
        if (MODE == 1) return {s[63:0], d[63:0]};
        if (MODE == 2) pr = (nop || w[0]) ? {64'd0, d[63:0]} : ({64'd0, d[63:0]} << 48);
        else           pr = {64'd0, d[63:0]} * {64'd0, (nop ? 64'd1 : w)};
        r = {2'b00, pr[63:0]} - {34'd0, pr[127:96]} + ({34'd0, pr[95:64]} << 32) - {34'd0, pr[95:64]};
        if (r[65])      r = r + {2'b00, P_MOD};
        else if (r[64]) r = r - {2'b00, P_MOD};
        return {s[63:0], r[63:0]};
    endfunction

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < LAT; i++) shV[i] <= 1'b0;
        end else begin
            if (shV[LAT-1] && ({bus.x_o, bus.y_o} !== refBfly(shX[LAT-1], shY[LAT-1], shW[LAT-1], shN[LAT-1]))) begin
                $display("ERROR gl64_bfly_core: x=%h y=%h w=%h nop=%b got x_o=%h y_o=%h expected %h",
                         shX[LAT-1], shY[LAT-1], shW[LAT-1], shN[LAT-1], bus.x_o, bus.y_o,
                         refBfly(shX[LAT-1], shY[LAT-1], shW[LAT-1], shN[LAT-1]));
                $finish;
            end
            if (bus.ce_i) begin
                shX[0] <= bus.x_i;
                shY[0] <= bus.y_i;
                shW[0] <= bus.w_i;
                shN[0] <= bus.nop_i;
                shV[0] <= 1'b1;
                for (int i = 1; i < LAT; i++) begin
                    shX[i] <= shX[i-1];
                    shY[i] <= shY[i-1];
                    shW[i] <= shW[i-1];
                    shN[i] <= shN[i-1];
                    shV[i] <= shV[i-1];
                end
            end
        end
    end
`endif
endmodule

// File: tb/tb_gl64_bfly_core.sv
// tb_gl64_bfly_core
// Drives four butterfly cores (GENERIC, W0, W0_W2, GENERIC+CANONICAL with the
// split multiplier) from one shared stimulus stream and compares every output,
// every cycle, against a field-arithmetic reference model held in a latency
// pipe per core. Directed vectors cover the documented corner values.
module tb_gl64_bfly_core;
    localparam logic [63:0] P_MOD  = 64'hFFFF_FFFF_0000_0001;
    localparam int          NDUT   = 4;
    localparam int          MAXLAT = 8;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b1;
    logic        ce    = 1'b0;
    logic        nop   = 1'b0;
    logic [63:0] xIn   = '0;
    logic [63:0] yIn   = '0;
    logic [63:0] wIn   = '0;
    int          checks = 0;
    int          errors = 0;

    int    dutMode  [NDUT] = '{0, 1, 2, 0};
    bit    dutCanon [NDUT] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int    dutLat   [NDUT] = '{8, 2, 5, 8};
    string dutName  [NDUT] = '{"generic", "w0", "w0w2", "genCanon"};

    logic [127:0] expPipe [NDUT][MAXLAT];
    logic [63:0]  outX [NDUT];
    logic [63:0]  outY [NDUT];

    gl64_bfly_core_if bus [NDUT] ();

    for (genvar g = 0; g < NDUT; g++) begin : g_drive
        assign bus[g].ce_i  = ce;
        assign bus[g].nop_i = nop;
        assign bus[g].x_i   = xIn;
        assign bus[g].y_i   = yIn;
        assign bus[g].w_i   = wIn;
        assign outX[g]      = bus[g].x_o;
        assign outY[g]      = bus[g].y_o;
    end

    gl64_bfly_core #(.MODE(0), .BFLYDSP(24), .CANONICAL(0)) dutGeneric  (.clk_i(clk), .rst_ni(rst_n), .bus(bus[0]));
    gl64_bfly_core #(.MODE(1), .BFLYDSP(24), .CANONICAL(0)) dutW0       (.clk_i(clk), .rst_ni(rst_n), .bus(bus[1]));
    gl64_bfly_core #(.MODE(2), .BFLYDSP(24), .CANONICAL(0)) dutW0W2     (.clk_i(clk), .rst_ni(rst_n), .bus(bus[2]));
    gl64_bfly_core #(.MODE(0), .BFLYDSP(16), .CANONICAL(1)) dutGenCanon (.clk_i(clk), .rst_ni(rst_n), .bus(bus[3]));

    always #5 clk = ~clk;

    // Reference butterfly straight from the field rules: fold the sum down by p
    // until it is below 2^64, lift the difference by p until it is non-negative,
    // then reduce the 128-bit product with the 2^96 = -1, 2^64 = 2^32 - 1 identity.
    function automatic logic [127:0] refBfly(int mode, bit canon, logic [63:0] x, logic [63:0] y,
                                             logic [63:0] w, bit byp);
        logic [127:0]        s;
        logic [127:0]        pr;
        logic signed [129:0] d;
        logic signed [129:0] r;
        s = byp ? {64'd0, x} : {64'd0, x} + {64'd0, y};
        while (s >= 128'h1_0000_0000_0000_0000) s = s - {64'd0, P_MOD};
        d = byp ? {66'd0, y} : {66'd0, x} - {66'd0, y};
        while (d < 0) d = d + {66'd0, P_MOD};
        if (canon && !byp) begin
            if (s >= {64'd0, P_MOD}) s = s - {64'd0, P_MOD};
            if (d >= {66'd0, P_MOD}) d = d - {66'd0, P_MOD};
        end
        if (mode == 1) return {s[63:0], d[63:0]};
        if (mode == 2) pr = (byp || w[0]) ? {64'd0, d[63:0]} : {64'd0, d[63:0]} * (128'd1 << 48);
        else           pr = {64'd0, d[63:0]} * {64'd0, (byp ? 64'd1 : w)};
        r = {66'd0, pr[63:0]};
        r = r - {98'd0, pr[127:96]};
        r = r + {98'd0, pr[95:64]} * 130'd4294967296;
        r = r - {98'd0, pr[95:64]};
        if (r < 0) r = r + {66'd0, P_MOD};
        else if (r >= 130'h1_0000_0000_0000_0000) r = r - {66'd0, P_MOD};
        return {s[63:0], r[63:0]};
    endfunction

    function automatic logic [63:0] randVal();
        case ($urandom_range(0, 5))
            0:       return P_MOD + 64'($urandom_range(0, 3)) - 64'd2;
            1:       return 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom_range(0, 3));
            2:       return 64'($urandom_range(0, 7));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic clearModel();
        for (int k = 0; k < NDUT; k++)
            for (int i = 0; i < MAXLAT; i++) expPipe[k][i] = '0;
    endtask

    // One clock: advance the model pipes on an enabled edge, then compare all outputs.
    task automatic stepCycle();
        @(posedge clk);
        if (rst_n && ce) begin
            for (int k = 0; k < NDUT; k++) begin
                for (int i = MAXLAT - 1; i > 0; i--) expPipe[k][i] = expPipe[k][i-1];
                expPipe[k][0] = refBfly(dutMode[k], dutCanon[k], xIn, yIn, wIn, nop);
            end
        end
        #1;
        for (int k = 0; k < NDUT; k++) begin
            checkOutput({dutName[k], " x_o"}, outX[k], expPipe[k][dutLat[k]-1][127:64]);
            checkOutput({dutName[k], " y_o"}, outY[k], expPipe[k][dutLat[k]-1][63:0]);
        end
    endtask

    task automatic applyStimulus(input logic ceV, input logic nopV, input logic [63:0] x,
                                 input logic [63:0] y, input logic [63:0] w);
        ce  = ceV;
        nop = nopV;
        xIn = x;
        yIn = y;
        wIn = w;
        stepCycle();
    endtask

    // Feed one vector, let it travel the given latency, and compare against literal results.
    task automatic directedCheck(input string tag, input int sel, input int lat,
                                 input logic [63:0] x, input logic [63:0] y, input logic [63:0] w,
                                 input logic byp, input logic [63:0] expX, input logic [63:0] expY);
        applyStimulus(1'b1, byp, x, y, w);
        repeat (lat - 1) applyStimulus(1'b1, 1'b0, 64'd0, 64'd0, 64'd0);
        checkOutput({tag, " x_o"}, outX[sel], expX);
        checkOutput({tag, " y_o"}, outY[sel], expY);
    endtask

    task automatic resetNow();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            checkOutput({dutName[k], " async rst x_o"}, outX[k], 64'd0);
            checkOutput({dutName[k], " async rst y_o"}, outY[k], 64'd0);
        end
        clearModel();
        repeat (2) applyStimulus(1'b1, 1'b0, randVal(), randVal(), randVal());
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < NDUT; k++) begin
            checkOutput({dutName[k], " reset x_o"}, outX[k], 64'd0);
            checkOutput({dutName[k], " reset y_o"}, outY[k], 64'd0);
        end
        clearModel();
        repeat (2) applyStimulus(1'b1, 1'b0, randVal(), randVal(), randVal());
        rst_n = 1'b1;

        directedCheck("basic",    0, 8, 64'd1, 64'd2, 64'd1, 1'b0, 64'd3, 64'hFFFF_FFFF_0000_0000);
        directedCheck("addWrap",  0, 8, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_0000_0000, 64'd7, 1'b0,
                      64'hFFFF_FFFE_FFFF_FFFF, 64'd0);
        directedCheck("fold",     0, 8, 64'h1_0000_0000, 64'd0, 64'h1_0000_0000, 1'b0,
                      64'h1_0000_0000, 64'h0000_0000_FFFF_FFFF);
        directedCheck("bypass",   0, 8, 64'd5, 64'd7, 64'hDEAD, 1'b1, 64'd5, 64'd7);
        directedCheck("w0",       1, 2, 64'd1, 64'd2, 64'd9, 1'b0, 64'd3, 64'hFFFF_FFFF_0000_0000);
        directedCheck("w2Shift",  2, 5, 64'd1, 64'd0, 64'd0, 1'b0, 64'd1, 64'h0001_0000_0000_0000);
        directedCheck("w2One",    2, 5, 64'd1, 64'd0, 64'd1, 1'b0, 64'd1, 64'd1);

        // Bypass and real butterflies interleaved back to back.
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) applyStimulus(1'b1, 1'b1, 64'd5, 64'd7, 64'hDEAD);
            else            applyStimulus(1'b1, 1'b0, randVal(), randVal(), randVal());
        end

        // Random stream with an explicit 3-cycle stall and a mid-stream reset.
        for (int i = 0; i < 300; i++) begin
            if (i == 100) begin
                repeat (3) applyStimulus(1'b0, 1'($urandom_range(0, 1)), randVal(), randVal(), randVal());
            end
            if (i == 200) resetNow();
            applyStimulus($urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0,
                          randVal(), randVal(), randVal());
        end
        repeat (MAXLAT) applyStimulus(1'b1, 1'b0, randVal(), randVal(), randVal());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
